interrupt_scheduler: RTL

- Sits between the interrupt sources (jump key, frame-ready, future game events) and the CPU interrupt-instruction input.
- Latches each source's one-cycle request as a pending bit and picks one eligible source by round-robin.
- Presents that source's 32-bit instruction word to the CPU, holds it until the CPU acknowledges, then enforces a minimum idle gap before the next issue.
- Replaces ad-hoc priority muxing: no request is lost when two sources fire in the same cycle or while the CPU is busy.

---
 rtl/interrupt_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/interrupt_scheduler.sv
// Round-robin interrupt scheduler: latches one-cycle source requests as pending bits,
// issues one instruction word at a time to the CPU, and enforces an idle gap between issues.
module interrupt_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                   proc_clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [32*NUM_SRC-1:0]  src_instr,
  input  logic [NUM_SRC-1:0]     irq_mask,
  input  logic                   cpu_ack,
  input  logic                   overrun_clr,
  output logic [31:0]            interrupt_instruction,
  output logic                   irq_valid,
  output logic [2:0]             grant_id,
  output logic [NUM_SRC-1:0]     pending,
  output logic [NUM_SRC-1:0]     overrun,
  output logic                   timeout
);

  localparam int PTR_W   = $clog2(NUM_SRC);
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_instr;
  logic               r_valid;
  logic               r_timeout;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_overrun;

  logic               w_ack;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_ovr_set;
  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_next_ptr;

  assign w_ack      = (r_state == WAIT_ACK) && cpu_ack;
  assign w_ovr_set  = src_req & r_pending & ~w_clr;
  assign w_elig     = r_pending & ~irq_mask;
  assign w_next_ptr = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_clr = '0;
    if (w_ack) w_clr[r_grant] = 1'b1;
  end

  // First eligible source at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge proc_clk) begin
    if (!reset) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      // A new request in the same cycle as the ack-clear re-arms the bit.
      r_pending <= (r_pending & ~w_clr) | src_req;
      r_overrun <= (overrun_clr ? '0 : r_overrun) | w_ovr_set;
    end
  end

  always_ff @(posedge proc_clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_instr <= src_instr[32*w_sel +: 32];
            r_grant <= w_sel;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // An ack landing on the timeout cycle is honoured as a normal ack.
          if (cpu_ack || (r_cnt == ACK_LAST)) begin
            r_timeout <= !cpu_ack;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_rr_ptr  <= w_next_ptr;
            r_cnt     <= '0;
            r_state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) r_state <= IDLE;
          else                   r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign interrupt_instruction = r_instr;
  assign irq_valid             = r_valid;
  assign grant_id              = 3'(r_grant);
  assign pending               = r_pending;
  assign overrun               = r_overrun;
  assign timeout               = r_timeout;

endmodule
